axi4_lite_slave_mem: RTL and testbench

- Parametrised AXI4-Lite slave memory responder: DEPTH words of DATA_WIDTH, mapped at BASE_ADDR.
- Per-channel programmable ready delays, byte strobes, protection-checked privileged window, and DECERR/SLVERR generation.
- Sits behind the slave agent's BFM in the HDL top as the DUT-side memory model.
- Replaces the fixed-width, no-delay slave model with a width/depth/delay-generalised one.

---
 rtl/axi4_lite_slave_mem_pkg.sv | 63 ++++++
 rtl/axi4_lite_slave_mem_if.sv | 43 ++++
 rtl/axi4_lite_ready_delay.sv | 35 +++
 rtl/axi4_lite_slave_mem.sv | 168 ++++++++++++++++
 tb/tb_axi4_lite_slave_mem.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared AXI4-Lite slave memory types: response/protection encodings, config bundle, FSM states.
package axi4_lite_slave_mem_pkg;

  localparam int unsigned ADDRESS_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned DELAY_WIDTH     = 5;
  localparam int unsigned MAX_DELAY_VALUE = 15;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  // bit0 privileged, bit1 non-secure, bit2 instruction
  typedef enum logic [2:0] {
    AWPROT_UNPRIV              = 3'b000,
    AWPROT_PRIV                = 3'b001,
    AWPROT_NONSEC_UNPRIV       = 3'b010,
    AWPROT_NONSEC_PRIV         = 3'b011,
    AWPROT_INSTR_UNPRIV        = 3'b100,
    AWPROT_INSTR_PRIV          = 3'b101,
    AWPROT_INSTR_NONSEC_UNPRIV = 3'b110,
    AWPROT_INSTR_NONSEC_PRIV   = 3'b111
  } awprot_e;

  typedef enum logic [2:0] {
    ARPROT_UNPRIV              = 3'b000,
    ARPROT_PRIV                = 3'b001,
    ARPROT_NONSEC_UNPRIV       = 3'b010,
    ARPROT_NONSEC_PRIV         = 3'b011,
    ARPROT_INSTR_UNPRIV        = 3'b100,
    ARPROT_INSTR_PRIV          = 3'b101,
    ARPROT_INSTR_NONSEC_UNPRIV = 3'b110,
    ARPROT_INSTR_NONSEC_PRIV   = 3'b111
  } arprot_e;

  typedef struct packed {
    logic [DELAY_WIDTH-1:0] awready_delay;
    logic [DELAY_WIDTH-1:0] wready_delay;
    logic [DELAY_WIDTH-1:0] arready_delay;
  } slave_mem_cfg_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'b00,
    WR_COMMIT = 2'b01,
    WR_RESP   = 2'b10
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between the master BFM and the slave memory model.
interface axi4_lite_slave_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = axi4_lite_slave_mem_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = axi4_lite_slave_mem_pkg::DATA_WIDTH
);

  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_ready_delay.sv
// Per-channel ready generator: ready rises once valid has waited the saturated configured delay.
module axi4_lite_ready_delay #(
  parameter int unsigned DELAY_WIDTH     = axi4_lite_slave_mem_pkg::DELAY_WIDTH,
  parameter int unsigned MAX_DELAY_VALUE = axi4_lite_slave_mem_pkg::MAX_DELAY_VALUE
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   valid,
  input  logic                   eligible,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  output logic                   ready_c
);

  localparam logic [DELAY_WIDTH-1:0] MAX_D = DELAY_WIDTH'(MAX_DELAY_VALUE);

  logic [DELAY_WIDTH-1:0] cnt;
  logic [DELAY_WIDTH-1:0] delay_c;

  // >= rather than == so a delay lowered mid-wait cannot strand the channel
  always_comb begin
    delay_c = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;
    ready_c = !areset && eligible && (cnt >= delay_c);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (valid && ready_c) begin
      cnt <= '0;
    end else if (valid && (cnt < delay_c)) begin
      cnt <= cnt + DELAY_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory model with programmable ready delays, byte strobes,
// a privileged low window and DECERR/SLVERR responses.
module axi4_lite_slave_mem #(
  parameter int unsigned ADDRESS_WIDTH = axi4_lite_slave_mem_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = axi4_lite_slave_mem_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH         = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(32'h0000_1000),
  parameter int unsigned PRIV_WORDS    = 0,
  parameter int unsigned DELAY_WIDTH   = axi4_lite_slave_mem_pkg::DELAY_WIDTH,
  parameter int unsigned MAX_DELAY_VALUE = axi4_lite_slave_mem_pkg::MAX_DELAY_VALUE
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_lite_slave_mem_if.slave   bus,
  input  logic [DELAY_WIDTH-1:0] cfg_awready_delay,
  input  logic [DELAY_WIDTH-1:0] cfg_wready_delay,
  input  logic [DELAY_WIDTH-1:0] cfg_arready_delay
);

  import axi4_lite_slave_mem_pkg::*;

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFS_W = $clog2(BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] WINDOW = ADDRESS_WIDTH'(DEPTH * BYTES);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  wr_state_e                wr_state;
  logic                     aw_done, w_done, awpriv_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [BYTES-1:0]         wstrb_q;
  logic                     bvalid_q;
  bresp_e                   bresp_q;

  rd_state_e                rd_state;
  logic                     rvalid_q;
  rresp_e                   rresp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic aw_hs_c, w_hs_c, ar_hs_c;
  logic [ADDRESS_WIDTH-1:0] wr_off_c, rd_off_c;
  logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
  logic wr_hit_c, rd_hit_c, wr_priv_c, rd_priv_c;
  bresp_e wr_resp_c;
  rresp_e rd_resp_c;

  axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH), .MAX_DELAY_VALUE(MAX_DELAY_VALUE)) u_aw_delay (
    .aclk(aclk), .areset(areset), .valid(bus.awvalid),
    .eligible(wr_state == WR_IDLE && !aw_done), .cfg_delay(cfg_awready_delay), .ready_c(bus.awready));

  axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH), .MAX_DELAY_VALUE(MAX_DELAY_VALUE)) u_w_delay (
    .aclk(aclk), .areset(areset), .valid(bus.wvalid),
    .eligible(wr_state == WR_IDLE && !w_done), .cfg_delay(cfg_wready_delay), .ready_c(bus.wready));

  axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH), .MAX_DELAY_VALUE(MAX_DELAY_VALUE)) u_ar_delay (
    .aclk(aclk), .areset(areset), .valid(bus.arvalid),
    .eligible(rd_state == RD_IDLE), .cfg_delay(cfg_arready_delay), .ready_c(bus.arready));

  // Unsigned wrap of the offset folds the below-base case into the single range compare
  always_comb begin
    aw_hs_c  = bus.awvalid && bus.awready;
    w_hs_c   = bus.wvalid && bus.wready;
    ar_hs_c  = bus.arvalid && bus.arready;
    wr_off_c = awaddr_q - BASE_ADDR;
    rd_off_c = bus.araddr - BASE_ADDR;
    wr_hit_c = wr_off_c < WINDOW;
    rd_hit_c = rd_off_c < WINDOW;
    wr_idx_c = IDX_W'(wr_off_c >> OFS_W);
    rd_idx_c = IDX_W'(rd_off_c >> OFS_W);
  end

  if (PRIV_WORDS == 0) begin : g_no_priv
    assign wr_priv_c = 1'b0;
    assign rd_priv_c = 1'b0;
  end else begin : g_priv
    assign wr_priv_c = 32'(wr_idx_c) < PRIV_WORDS;
    assign rd_priv_c = 32'(rd_idx_c) < PRIV_WORDS;
  end

  always_comb begin
    wr_resp_c = BRESP_OKAY;
    rd_resp_c = RRESP_OKAY;
    if (!wr_hit_c)                  wr_resp_c = BRESP_DECERR;
    else if (wr_priv_c && !awpriv_q) wr_resp_c = BRESP_SLVERR;
    if (!rd_hit_c)                  rd_resp_c = RRESP_DECERR;
    else if (rd_priv_c && !bus.arprot[0]) rd_resp_c = RRESP_SLVERR;
  end

  // Write path: collect AW and W in any order, commit for one cycle, then hold B
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      awaddr_q <= '0;
      awpriv_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= BRESP_OKAY;
      mem      <= '{default: '0};
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs_c) begin
            awaddr_q <= bus.awaddr;
            awpriv_q <= bus.awprot[0];
            aw_done  <= 1'b1;
          end
          if (w_hs_c) begin
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
            w_done  <= 1'b1;
          end
          if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) wr_state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          if (wr_resp_c == BRESP_OKAY) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (wstrb_q[b]) mem[wr_idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
          bresp_q  <= wr_resp_c;
          bvalid_q <= 1'b1;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read path: memory sampled at the AR edge, so a same-edge commit is not yet visible
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= RD_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RRESP_OKAY;
      rdata_q  <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs_c) begin
        rdata_q  <= (rd_resp_c == RRESP_OKAY) ? mem[rd_idx_c] : '0;
        rresp_q  <= rd_resp_c;
        rvalid_q <= 1'b1;
        rd_state <= RD_RESP;
      end
    end else if (bus.rready) begin
      rvalid_q <= 1'b0;
      rd_state <= RD_IDLE;
    end
  end

  assign bus.bvalid = bvalid_q;
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rresp  = rresp_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed self-checking bench for axi4_lite_slave_mem (DEPTH 16 at 0x1000, two privileged words).
module tb_axi4_lite_slave_mem;

  import axi4_lite_slave_mem_pkg::*;

  logic           aclk = 1'b0;
  logic           areset;
  slave_mem_cfg_t cfg;
  int             n_tests = 0;
  int             n_fail  = 0;
  logic           early_b;

  logic [31:0] rd;
  logic [1:0]  rs;
  int          ac, wc;
  logic        rv;

  axi4_lite_slave_mem_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_mem #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0000_1000),
    .PRIV_WORDS(2), .DELAY_WIDTH(5), .MAX_DELAY_VALUE(15)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus),
    .cfg_awready_delay(cfg.awready_delay),
    .cfg_wready_delay(cfg.wready_delay),
    .cfg_arready_delay(cfg.arready_delay)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // W goes valid w_lead cycles before AW; counts valid cycles up to each handshake
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int w_lead,
                          output logic [1:0] resp, output int aw_cyc, output int w_cyc);
    logic aw_ok, w_ok, aw_f, w_f;
    int k;
    aw_ok = 1'b0; w_ok = 1'b0; k = 0; aw_cyc = 0; w_cyc = 0; early_b = 1'b0;
    @(posedge aclk); #1;
    bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb;
    bus.wvalid = 1'b1; bus.awvalid = (w_lead == 0);
    while (!(aw_ok && w_ok) && k < 200) begin
      #1;
      if (bus.awvalid) aw_cyc++;
      if (bus.wvalid)  w_cyc++;
      if (bus.bvalid)  early_b = 1'b1;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (aw_f) begin bus.awvalid = 1'b0; aw_ok = 1'b1; end
      if (w_f)  begin bus.wvalid = 1'b0;  w_ok = 1'b1;  end
      k++;
      if (!aw_ok && k >= w_lead) bus.awvalid = 1'b1;
    end
    check("wr_addr_data_accepted", {aw_ok, w_ok}, 2'b11);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; k = 0;
    #1;
    while (!bus.bvalid && k < 50) begin @(posedge aclk); #2; k++; end
    check("wr_bvalid_seen", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int ar_cyc, output logic rv1);
    int k;
    k = 0;
    @(posedge aclk); #1;
    bus.araddr = addr; bus.arprot = prot; bus.arvalid = 1'b1;
    #1;
    ar_cyc = 1;
    while (!bus.arready && k < 50) begin @(posedge aclk); #2; k++; ar_cyc++; end
    check("rd_arready_seen", bus.arready, 1'b1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    #1;
    rv1 = bus.rvalid; data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    #1;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [1:0] exp_resp);
    logic [1:0] r;
    int a, w;
    do_write(addr, data, strb, prot, 0, r, a, w);
    check({tag, "_bresp"}, r, exp_resp);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0] r;
    int a;
    logic v;
    do_read(addr, prot, d, r, a, v);
    check({tag, "_rvalid_lat1"}, v, 1'b1);
    check({tag, "_rresp"}, r, exp_resp);
    check({tag, "_rdata"}, d, exp_data);
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    cfg = '0;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("rst_resps", {bus.bresp, bus.rresp}, 4'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;

    // zero delays: ready on first valid cycle, read latency 1
    do_write(32'h1004, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, rs, ac, wc);
    check("t1_aw_cycles", ac, 1);
    check("t1_w_cycles", wc, 1);
    check("t1_bresp", rs, BRESP_OKAY);
    do_read(32'h1004, 3'b001, rd, rs, ac, rv);
    check("t1_ar_cycles", ac, 1);
    check("t1_rvalid_lat1", rv, 1'b1);
    check("t1_rresp", rs, RRESP_OKAY);
    check("t1_rdata", rd, 32'hDEAD_BEEF);

    // AW delay 3, W delay 20 saturating to 15, W leads by 2 cycles
    cfg.awready_delay = 5'd3; cfg.wready_delay = 5'd20;
    do_write(32'h1010, 32'h0000_0077, 4'hF, 3'b001, 2, rs, ac, wc);
    check("t2_aw_cycles", ac, 4);
    check("t2_w_cycles", wc, 16);
    check("t2_no_early_bvalid", early_b, 1'b0);
    check("t2_bresp", rs, BRESP_OKAY);
    check("t2_single_bvalid", bus.bvalid, 1'b0);
    cfg = '0;
    cfg.arready_delay = 5'd2;
    do_read(32'h1010, 3'b001, rd, rs, ac, rv);
    check("t2_ar_cycles", ac, 3);
    check("t2_rdata", rd, 32'h0000_0077);
    cfg = '0;

    // byte strobes merge into existing word
    wr_chk("t3_fill", 32'h1008, 32'hFFFF_FFFF, 4'hF, 3'b001, BRESP_OKAY);
    wr_chk("t3_strb", 32'h1008, 32'h1122_3344, 4'h5, 3'b001, BRESP_OKAY);
    rd_chk("t3_read", 32'h1008, 3'b001, 32'hFF22_FF44, RRESP_OKAY);

    // privileged window
    wr_chk("t4_unpriv_wr", 32'h1000, 32'h0000_5555, 4'hF, 3'b000, BRESP_SLVERR);
    rd_chk("t4_unchanged", 32'h1000, 3'b001, 32'h0, RRESP_OKAY);
    wr_chk("t4_priv_wr", 32'h1000, 32'h0000_5555, 4'hF, 3'b001, BRESP_OKAY);
    rd_chk("t4_priv_rd", 32'h1000, 3'b001, 32'h0000_5555, RRESP_OKAY);
    rd_chk("t4_unpriv_rd", 32'h1000, 3'b000, 32'h0, RRESP_SLVERR);

    // decode errors and window edges
    wr_chk("t5_decerr_wr", 32'h2000, 32'h1234_5678, 4'hF, 3'b001, BRESP_DECERR);
    rd_chk("t5_no_alias", 32'h1000, 3'b001, 32'h0000_5555, RRESP_OKAY);
    rd_chk("t5_below_base", 32'h0FFC, 3'b001, 32'h0, RRESP_DECERR);
    rd_chk("t5_last_word", 32'h103C, 3'b000, 32'h0, RRESP_OKAY);
    rd_chk("t5_past_end", 32'h1040, 3'b001, 32'h0, RRESP_DECERR);
    rd_chk("t5_unaligned", 32'h1007, 3'b001, 32'hDEAD_BEEF, RRESP_OKAY);

    // AR handshake on the commit edge sees the old word; then reset drops both responses
    wr_chk("t6_old", 32'h100C, 32'h0000_000A, 4'hF, 3'b001, BRESP_OKAY);
    @(posedge aclk); #1;
    bus.awaddr = 32'h100C; bus.awprot = 3'b001; bus.wdata = 32'h0000_000B; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0; bus.rready = 1'b0;
    #1;
    check("t6_aw_w_ready", {bus.awready, bus.wready}, 2'b11);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h100C; bus.arprot = 3'b001; bus.arvalid = 1'b1;
    #1;
    check("t6_arready", bus.arready, 1'b1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    #1;
    check("t6_both_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    check("t6_rdata_old", bus.rdata, 32'h0000_000A);
    repeat (4) @(posedge aclk);
    #2;
    check("t6_held_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    check("t6_held_rdata", bus.rdata, 32'h0000_000A);
    #1;
    areset = 1'b1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    check("t6_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("t6_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("t6_rst_rdata", bus.rdata, 32'h0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #2;
    check("t6_post_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    rd_chk("t6_cleared", 32'h100C, 3'b001, 32'h0, RRESP_OKAY);
    rd_chk("t6_cleared2", 32'h1004, 3'b001, 32'h0, RRESP_OKAY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
